// File: rtl/demux_pkg.sv
// Shared channel-count constants, select type and one-hot decode helper
// for the buffered 1:4 demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // Decode a channel select into a 4-bit one-hot load vector.
    function automatic logic [3:0] onehot4(ch_sel_t sel);
        onehot4 = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux_ch_slot.sv
// One-entry output buffer for a single demux channel. Holds a word until
// the consumer takes it; a load in the same cycle as a drain keeps the
// slot full, so back-to-back words flow at one per cycle.
module demux_ch_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out
);

    // Occupancy and data register: flush empties, load fills, drain empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            data_out <= '0;
        end else if (flush) begin
            // Data is deliberately left in place; only occupancy is cleared.
            valid <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            data_out <= data_in;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_to_4_buffered.sv
// Registered, valid/ready 1:4 demultiplexer. The destination is either the
// external {S1,S0} select or an internal round-robin pointer. Each channel
// owns a one-entry buffer, so upstream stalls only on the channel it targets.
module demux_1_to_4_buffered
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     S1,
    input  logic                     S0,
    input  logic                     auto_mode,
    input  logic                     flush,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]         rr_ptr
);

    ch_sel_t           dest;
    logic              accept;
    logic [NUM_CH-1:0] load;

    // Destination select, ready and load decode. Ready never looks at
    // in_valid, and a full slot being drained this cycle can still accept.
    always_comb begin
        dest     = auto_mode ? ch_sel_t'(rr_ptr) : ch_sel_t'({S1, S0});
        in_ready = !flush && (!out_valid[dest] || out_ready[dest]);
        accept   = in_valid && in_ready;
        load     = onehot4(dest) & {NUM_CH{accept}};
    end

    // Round-robin pointer: advances only on accepts in auto mode, cleared by
    // flush, and untouched when auto_mode toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (accept && auto_mode) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_ch_slot #(.DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .load     (load[k]),
            .data_in  (in_data),
            .valid    (out_valid[k]),
            .ready    (out_ready[k]),
            .data_out (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_demux_1_to_4_buffered.sv
// Directed bench for the buffered 1:4 demux: routing, back-pressure,
// round-robin wrap, drain+reload, flush and asynchronous reset.
module tb_demux_1_to_4_buffered;

    localparam int DATA_W = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          S1, S0;
    logic          auto_mode;
    logic          flush;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [31:0]   out_data;
    logic [1:0]    rr_ptr;

    int checks = 0;
    int errors = 0;

    demux_1_to_4_buffered #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .S1        (S1),
        .S0        (S0),
        .auto_mode (auto_mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; S1 = 1'b0; S0 = 1'b0;
        auto_mode = 1'b0; flush = 1'b0; out_ready = 4'b0000;
        #12;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", out_data); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr got %0d want 0", rr_ptr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_route();
        auto_mode = 1'b0; {S1, S0} = 2'b10; in_data = 8'hA5; in_valid = 1'b1; out_ready = 4'b1111;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0100) begin errors++; $display("FAIL route_valid got %b want 0100", out_valid); end
        checks++; if (out_data[23:16] !== 8'hA5) begin errors++; $display("FAIL route_data got %h want a5", out_data[23:16]); end
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL route_drain got %b want 0000", out_valid); end
    endtask

    task automatic test_back_pressure();
        out_ready = 4'b1101; {S1, S0} = 2'b01; in_data = 8'h11; in_valid = 1'b1;
        tick();
        in_data = 8'h22;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got %b want 0", in_ready); end
        checks++; if (out_data[15:8] !== 8'h11) begin errors++; $display("FAIL bp_hold got %h want 11", out_data[15:8]); end
        tick();
        checks++; if (out_data[15:8] !== 8'h11 || out_valid !== 4'b0010) begin errors++; $display("FAIL bp_hold2 got %h/%b want 11/0010", out_data[15:8], out_valid); end
        out_ready = 4'b1111;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h22) begin errors++; $display("FAIL bp_second got %b/%h want 0010/22", out_valid, out_data[15:8]); end
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drain got %b want 0000", out_valid); end
    endtask

    task automatic test_rr_wrap();
        logic [3:0] exp_v [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        auto_mode = 1'b1; out_ready = 4'b1111; {S1, S0} = 2'b11;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            #1;
            checks++; if (rr_ptr !== exp_ch[i]) begin errors++; $display("FAIL rr_ptr_%0d got %0d want %0d", i, rr_ptr, exp_ch[i]); end
            tick();
            checks++; if (out_valid !== exp_v[i] || out_data[exp_ch[i]*8 +: 8] !== 8'(i))
                begin errors++; $display("FAIL rr_word_%0d got %b/%h want %b/%h", i, out_valid, out_data[exp_ch[i]*8 +: 8], exp_v[i], 8'(i)); end
        end
        in_valid = 1'b0;
        #1;
        checks++; if (rr_ptr !== 2'd2) begin errors++; $display("FAIL rr_end got %0d want 2", rr_ptr); end
        tick();
    endtask

    task automatic test_back_to_back();
        auto_mode = 1'b0; {S1, S0} = 2'b11; out_ready = 4'b0000; in_data = 8'h33; in_valid = 1'b1;
        tick();
        out_ready = 4'b1000; in_data = 8'h44;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h44) begin errors++; $display("FAIL b2b_reload got %b/%h want 1000/44", out_valid, out_data[31:24]); end
        tick();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain got %b want 0000", out_valid); end
    endtask

    task automatic test_flush();
        // rr_ptr is 2 here from the round-robin scenario.
        auto_mode = 1'b0; out_ready = 4'b0000; in_valid = 1'b1;
        {S1, S0} = 2'b00; in_data = 8'h0A; tick();
        {S1, S0} = 2'b10; in_data = 8'h0C; tick();
        {S1, S0} = 2'b01; in_data = 8'h5A; flush = 1'b1;
        #1;
        checks++; if (out_valid !== 4'b0101) begin errors++; $display("FAIL flush_pre got %b want 0101", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        checks++; if (out_valid !== 4'b0000 || rr_ptr !== 2'd0) begin errors++; $display("FAIL flush_clear got %b/%0d want 0000/0", out_valid, rr_ptr); end
        checks++; if (out_data[7:0] !== 8'h0A) begin errors++; $display("FAIL flush_data_kept got %h want 0a", out_data[7:0]); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b0010 || out_data[15:8] !== 8'h5A) begin errors++; $display("FAIL flush_pending got %b/%h want 0010/5a", out_valid, out_data[15:8]); end
    endtask

    task automatic test_async_reset();
        // ch1 still holds 8'h5A with out_ready=0; add ch0 and ch3.
        in_valid = 1'b1;
        {S1, S0} = 2'b00; in_data = 8'h01; tick();
        {S1, S0} = 2'b11; in_data = 8'h03; tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 4'b1011) begin errors++; $display("FAIL areset_pre got %b want 1011", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000 || out_data !== 32'h0 || rr_ptr !== 2'd0)
            begin errors++; $display("FAIL areset_clear got %b/%h/%0d want 0000/00000000/0", out_valid, out_data, rr_ptr); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_route();
        test_back_pressure();
        test_rr_wrap();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
